// File: rtl/discrete_filter_scheduler.sv
// Time-multiplexed single-pole RC filter shared across NUM_CH channels.
// Optional DISCRETE_SCHED_ROUND_EN: round-half-up in the MAC instead of floor.
module discrete_filter_scheduler #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CLOCK_RATE  = 1000000,
    parameter int unsigned SAMPLE_RATE = 48000
) (
    input  logic                   clk,
    input  logic                   I_RST,
    input  logic                   audio_clk_en,
    input  logic [16*NUM_CH-1:0]   in_data,
    input  logic [16*NUM_CH-1:0]   coef,
    input  logic [NUM_CH-1:0]      hp_sel,
    input  logic                   clear_overrun,
    output logic [16*NUM_CH-1:0]   out_data,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("discrete_filter_scheduler: NUM_CH must be 1..16");
    end
    if (CLOCK_RATE / SAMPLE_RATE < 3 * NUM_CH + 2) begin : g_bad_rate
        $error("discrete_filter_scheduler: too few clocks per sample for NUM_CH");
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_WRITE, S_DONE} state_t;

    state_t                  state;
    logic [CH_W-1:0]         ch;
    logic signed [15:0]      x_snap [NUM_CH];
    logic        [15:0]      a_snap [NUM_CH];
    logic [NUM_CH-1:0]       hp_snap;
    logic signed [15:0]      y_mem  [NUM_CH];
    logic signed [15:0]      shadow [NUM_CH];
    logic signed [16:0]      diff;
    logic signed [17:0]      delta;

    logic signed [15:0]      x_cur;
    logic signed [15:0]      y_cur;
    logic        [15:0]      a_cur;
    logic signed [33:0]      prod;
    logic signed [17:0]      delta_c;
    logic signed [18:0]      sum;
    logic signed [15:0]      y_new;
    logic signed [16:0]      hp_diff;
    logic signed [15:0]      result;

    function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
        if (v > 19'sd32767)
            return 16'sh7FFF;
        else if (v < -19'sd32768)
            return 16'sh8000;
        else
            return 16'(v);
    endfunction

    // Shared datapath for the channel currently addressed by ch
    always_comb begin
        x_cur   = x_snap[ch];
        y_cur   = y_mem[ch];
        a_cur   = a_snap[ch];
        prod    = 34'(diff) * 34'($signed({1'b0, a_cur}));
`ifdef DISCRETE_SCHED_ROUND_EN
        delta_c = 18'((prod + 34'sd32768) >>> 16);
`else
        delta_c = 18'(prod >>> 16);
`endif
        sum     = 19'(y_cur) + 19'(delta);
        y_new   = sat16(sum);
        hp_diff = 17'(x_cur) - 17'(y_new);
        result  = hp_snap[ch] ? sat16(19'(hp_diff)) : y_new;
    end

    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            state     <= S_IDLE;
            ch        <= '0;
            diff      <= '0;
            delta     <= '0;
            hp_snap   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            out_data  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                x_snap[i] <= '0;
                a_snap[i] <= '0;
                y_mem[i]  <= '0;
                shadow[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;

            // A tick during any non-idle state is dropped; set beats clear
            if (audio_clk_en && state != S_IDLE)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (audio_clk_en) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            x_snap[i] <= in_data[16*i +: 16];
                            a_snap[i] <= coef[16*i +: 16];
                        end
                        hp_snap <= hp_sel;
                        ch      <= '0;
                        busy    <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    diff  <= 17'(x_cur) - 17'(y_cur);
                    state <= S_MAC;
                end
                S_MAC: begin
                    delta <= delta_c;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    y_mem[ch]  <= y_new;
                    shadow[ch] <= result;
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        // Publish in the DONE cycle, folding in the last channel's result
                        for (int unsigned i = 0; i < NUM_CH; i++)
                            out_data[16*i +: 16] <= (CH_W'(i) == ch) ? result : shadow[i];
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_discrete_filter_scheduler.sv
// Randomized bench for discrete_filter_scheduler against a sweep-level reference model.
module tb_discrete_filter_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 3 * N + 1;

    logic              clk = 1'b0;
    logic              I_RST;
    logic              audio_clk_en;
    logic [16*N-1:0]   in_data;
    logic [16*N-1:0]   coef;
    logic [N-1:0]      hp_sel;
    logic              clear_overrun;
    logic [16*N-1:0]   out_data;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    always #5 clk = ~clk;

    discrete_filter_scheduler #(
        .NUM_CH(N), .CLOCK_RATE(1000000), .SAMPLE_RATE(48000)
    ) dut (
        .clk(clk), .I_RST(I_RST), .audio_clk_en(audio_clk_en),
        .in_data(in_data), .coef(coef), .hp_sel(hp_sel),
        .clear_overrun(clear_overrun), .out_data(out_data),
        .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Stimulus values presented on the inputs
    int x_v [N];
    int a_v [N];
    bit hp_v[N];

    // Reference model: filter state, results awaiting publication, published outputs
    int m_y   [N];
    int m_pend[N];
    int m_out [N];
    int left;
    bit m_ovr;
    bit m_valid;

    task automatic chk_int(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic chk_vec(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic int sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int dut_ch(input int c);
        logic [15:0] t;
        t = out_data[16*c +: 16];
        return int'($signed(t));
    endfunction

    function automatic logic [63:0] exp_out();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < int'(N); i++) v[16*i +: 16] = 16'(m_out[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_y[i] = 0; m_pend[i] = 0; m_out[i] = 0;
        end
        left = 0; m_ovr = 0; m_valid = 0;
    endtask

    // One clock edge of behaviour: a whole sweep is computed on acceptance,
    // its results appear SW-1 edges later for a single cycle.
    task automatic model_edge(input bit tick, input bit clr);
        bit     busy_b;
        longint prod;
        int     diff, yn;
        busy_b = (left > 0);
        if (tick && busy_b) m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (left > 0) left--;
        m_valid = 0;
        if (tick && !busy_b) begin
            for (int c = 0; c < int'(N); c++) begin
                diff = x_v[c] - m_y[c];
                prod = longint'(diff) * longint'(a_v[c]);
`ifdef DISCRETE_SCHED_ROUND_EN
                prod = prod + 32768;
`endif
                yn = sat(longint'(m_y[c]) + (prod >>> 16));
                m_pend[c] = hp_v[c] ? sat(longint'(x_v[c] - yn)) : yn;
                m_y[c] = yn;
            end
            left = SW;
        end else if (left == 1) begin
            m_valid = 1;
            for (int c = 0; c < int'(N); c++) m_out[c] = m_pend[c];
        end
    endtask

    task automatic compare_all();
        chk_int("busy", busy, (left > 0) ? 1 : 0);
        chk_int("out_valid", out_valid, m_valid);
        chk_int("overrun", overrun, m_ovr);
        chk_vec("out_data", out_data, exp_out());
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < int'(N); i++) begin
            in_data[16*i +: 16] = 16'(x_v[i]);
            coef[16*i +: 16]    = 16'(a_v[i]);
            hp_sel[i]           = hp_v[i];
        end
    endtask

    task automatic step(input bit tick, input bit clr);
        drive_inputs();
        audio_clk_en  = tick;
        clear_overrun = clr;
        @(posedge clk);
        #1;
        if (I_RST) model_reset();
        else model_edge(tick, clr);
        compare_all();
        audio_clk_en  = 1'b0;
        clear_overrun = 1'b0;
    endtask

    task automatic set_all(input int x, input int a, input bit hp);
        for (int i = 0; i < int'(N); i++) begin
            x_v[i] = x; a_v[i] = a; hp_v[i] = hp;
        end
    endtask

    task automatic sweep(input int c, input int lit, input string nm);
        step(1'b1, 1'b0);
        for (int k = 1; k <= int'(SW); k++) begin
            step(1'b0, 1'b0);
            if (k == int'(SW) - 1) begin
                chk_int({nm, "_valid"}, out_valid, 1);
                chk_int(nm, dut_ch(c), lit);
            end
        end
        chk_int({nm, "_busy_end"}, busy, 0);
    endtask

    int nvalid;

    initial begin
        I_RST         = 1'b1;
        audio_clk_en  = 1'b0;
        clear_overrun = 1'b0;
        set_all(0, 0, 1'b0);
        drive_inputs();
        model_reset();

        repeat (3) step(1'b0, 1'b0);
        I_RST = 1'b0;
        repeat (100) step(1'b0, 1'b0);
        chk_vec("idle_out", out_data, 64'h0);

        // Low-pass step response on ch0
        x_v[0] = 16384; a_v[0] = 32768;
        sweep(0, 8192,  "lp1");
        sweep(0, 12288, "lp2");
        sweep(0, 14336, "lp3");

        // High-pass step response on ch1, ch0 frozen with alpha 0
        a_v[0] = 0;
        x_v[1] = 16384; a_v[1] = 32768; hp_v[1] = 1'b1;
        sweep(1, 8192, "hp1");
        chk_int("hp1_ch3", dut_ch(3), 0);
        sweep(1, 4096, "hp2");
        sweep(1, 2048, "hp3");
        chk_int("hp3_ch2", dut_ch(2), 0);

        // Saturation on ch2
        a_v[1] = 0;
        x_v[2] = 32767; a_v[2] = 65535;
        sweep(2, 32766, "sat_lp");
        x_v[2] = -32768; a_v[2] = 0; hp_v[2] = 1'b1;
        sweep(2, -32768, "sat_hp");
        chk_int("sat_y_held", m_y[2], 32766);

        // Overrun: second tick 5 cycles after the first is dropped
        nvalid = 0;
        step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk_int("ovr_set", overrun, 1);
        for (int k = 0; k < 9; k++) begin
            step(1'b0, 1'b0);
            if (out_valid) nvalid++;
        end
        chk_int("ovr_one_valid", nvalid, 1);
        step(1'b0, 1'b1);
        chk_int("ovr_clear", overrun, 0);
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk_int("ovr_set_wins", overrun, 1);
        repeat (12) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Reset inside ch2 of a sweep
        step(1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b0);
        I_RST = 1'b1;
        #1;
        model_reset();
        chk_int("rst_busy", busy, 0);
        chk_vec("rst_out", out_data, 64'h0);
        chk_int("rst_valid", out_valid, 0);
        repeat (2) step(1'b0, 1'b0);
        I_RST = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b0);
            if (out_valid) nvalid++;
        end
        chk_int("rst_no_valid", nvalid, 0);
        set_all(0, 0, 1'b0);
        x_v[0] = 16384; a_v[0] = 32768;
        sweep(0, 8192, "rst_lp");

        // Randomized traffic, inputs changing freely during sweeps
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < int'(N); i++) begin
                if ($urandom_range(0, 3) == 0) x_v[i] = int'($signed(16'($urandom)));
                if ($urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       a_v[i] = 0;
                        1:       a_v[i] = 65535;
                        default: a_v[i] = int'($urandom_range(0, 65535));
                    endcase
                end
                if ($urandom_range(0, 15) == 0) hp_v[i] = 1'($urandom);
            end
            if ($urandom_range(0, 799) == 0) begin
                I_RST = 1'b1;
                step(1'b0, 1'b0);
                I_RST = 1'b0;
            end else begin
                step($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/discrete_filter_scheduler.md
Name: discrete_filter_scheduler

Overview:
- Time-multiplexes one single-pole RC filter datapath (y += (x − y)·α) across NUM_CH sound channels.
- Replaces per-node resistor_capacitor_low/high_pass_filter instances in discrete sound circuits, so FPGA multipliers are shared.
- On each audio_clk_en tick it snapshots all channel inputs, walks the channels in order through a 3-cycle FETCH/MAC/WRITE sequence, then publishes all outputs at once with a valid pulse.

Parameters:
- NUM_CH, 4, number of filter channels sharing the datapath (1..16).
- CLOCK_RATE, 1000000, system clock in Hz; must satisfy CLOCK_RATE/SAMPLE_RATE ≥ 3·NUM_CH+2.
- SAMPLE_RATE, 48000, audio_clk_en rate in Hz; used only by the elaboration-time check of the constraint above.

Ports:
- clk, in, 1, system clock.
- I_RST, in, 1, asynchronous active-high reset.
- audio_clk_en, in, 1, sample tick, one clk wide.
- in_data, in, 16·NUM_CH, signed channel inputs, channel i at [16i+15:16i].
- coef, in, 16·NUM_CH, unsigned α per channel, Q0.16.
- hp_sel, in, NUM_CH, 1 = channel outputs high-pass (x − y); 0 = low-pass (y).
- clear_overrun, in, 1, clears the overrun flag.
- out_data, out, 16·NUM_CH, signed filtered outputs, double-buffered.
- out_valid, out, 1, one-cycle pulse when out_data updates.
- busy, out, 1, high while a sweep is in progress.
- overrun, out, 1, sticky flag: a tick arrived while busy.

Behaviour:
- Reset: all outputs 0, all channel state y[i] = 0, FSM = IDLE, channel counter = 0. Reset is asynchronous; a mid-sweep reset aborts immediately and no out_valid follows.
- FSM states: IDLE → FETCH → MAC → WRITE → (next channel: FETCH | last channel: DONE) → IDLE.
- IDLE: when audio_clk_en is seen in cycle T, capture in_data, coef and hp_sel into snapshot registers, set ch = 0, go to FETCH.
- FETCH: read y[ch]; compute diff = x[ch] − y[ch] as 17-bit signed.
- MAC: prod = diff · α, 34-bit signed with α zero-extended; delta = prod >>> 16 (arithmetic, floor).
- WRITE:
  - y_new = sat16(y + delta); store to y[ch].
  - result = hp ? sat16(x − y_new) : y_new, written to the shadow buffer.
  - Increment ch.
- DONE: copy the shadow buffer to out_data; out_valid = 1 for this cycle only.
- Timing: DONE occurs at cycle T+3·NUM_CH+1 (T+13 for NUM_CH=4). busy is high from T+1 through the DONE cycle inclusive.
- sat16: clamp to [−32768, 32767].
- α = 0: state holds. α = 65535: y converges to within 1 LSB of x.
- audio_clk_en while busy (including the DONE cycle): tick ignored, overrun ← 1.
- Simultaneous clear_overrun and a new overrun event in the same cycle: the set wins.
- Snapshot isolation: in_data, coef and hp_sel changes during a sweep do not affect that sweep.
- out_data is stable between out_valid pulses.

Optional Feature:
- Macro: DISCRETE_SCHED_ROUND_EN.
- Defined: MAC adds 0x8000 to prod before >>> 16 (round half up).
- Undefined: plain floor via arithmetic shift.
- Test values below assume undefined; with the macro defined, the expected values must be recomputed accordingly.

Test Plan:
- Reset/idle: assert I_RST, release, no ticks → out_data = 0, busy = 0, out_valid = 0, overrun = 0 for 100 cycles.
- Low-pass step: ch0 x = 16384, α = 32768, hp_sel = 0, three ticks → ch0 out = 8192, 12288, 14336. out_valid pulses exactly 13 cycles after each tick (NUM_CH=4); busy spans 13 cycles.
- High-pass step: ch1 x = 16384, α = 32768, hp_sel[1] = 1, three ticks → ch1 out = 8192, 4096, 2048. Other channels with x = 0 stay 0.
- Saturation: ch2 x = 32767, α = 65535, one tick → y = 32766. Then x = −32768, α = 0, hp_sel[2] = 1, one tick → out = −32768 (saturated), y remains 32766.
- Overrun: two ticks 5 cycles apart → only one out_valid, at tick1+13; overrun = 1 from tick2+1. Pulse clear_overrun → overrun = 0. clear_overrun coincident with a new overrun event → overrun stays 1.
- Reset mid-sweep: tick, then assert I_RST at tick+7 (inside ch2) → busy = 0 and out_data = 0 immediately, no out_valid. After release, a tick with ch0 x = 16384, α = 32768 → 8192, proving state was cleared.
